mem_req_ctrl: RTL and testbench

Parametrised load/store request controller for the MEM stage. It is the successor to the single-cycle pulse request generator. It drives a handshaked data-bus interface (req/addr_ok/data_ok) instead of fire-and-forget enables. It supports a configurable data width (32 or 64), detects misaligned accesses, and returns aligned, sign- or zero-extended load data to the pipeline. It sits between the EX/MEM pipeline register and the data-side bus bridge.

---
 rtl/mem_req_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: load/store request controller for the MEM stage.
// Turns one accepted memory instruction into a single handshaked bus
// transaction (request phase, then response phase), positions store data
// and strobes on the byte lanes, and returns aligned, extended load data.
//
// Handshake semantics (da_* side): da_req is a valid. Once raised, da_req
// and every da_* field stay stable until a clock edge that samples
// da_addr_ok = 1. That edge completes the request phase. The next edge that
// samples da_data_ok = 1 completes the response phase. da_data_ok is only
// honoured in the response phase, so a da_data_ok seen during the request
// phase (including the da_addr_ok cycle) is ignored. A transaction is never
// withdrawn: a flush only suppresses the completion pulse.
module mem_req_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mem_valid,
  input  logic                  mem_flush,
  input  logic                  mem_is_store,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_busy,
  output logic                  ld_valid,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  st_done,
  output logic                  ale,
  output logic                  da_req,
  output logic                  da_wr,
  output logic [DATA_W/8-1:0]   da_wstrb,
  output logic [ADDR_W-1:0]     da_addr,
  output logic [DATA_W-1:0]     da_wdata,
  input  logic                  da_addr_ok,
  input  logic                  da_data_ok,
  input  logic [DATA_W-1:0]     da_rdata
);

  localparam int OFS_W  = $clog2(DATA_W/8);
  localparam int STRB_W = DATA_W/8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic                cancel_q;
  logic [OFS_W-1:0]    ofs_q;
  logic [1:0]          size_q;
  logic                uns_q;

  logic [OFS_W-1:0]    ofs;
  logic [2:0]          ofs3;
  logic                misaligned;
  logic [STRB_W-1:0]   strb_base;
  logic [STRB_W-1:0]   strb_sh;
  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   wdata_sh;
  logic [DATA_W-1:0]   rd_sh;
  logic [DATA_W-1:0]   keep;
  logic                sgn;
  logic [DATA_W-1:0]   ld_ext;
  logic                accept;
  logic                cancelled;

  assign mem_busy  = (state != IDLE);
  // The pipeline still shows the finished instruction during a pulse cycle,
  // so nothing is accepted until the following cycle.
  assign accept    = (state == IDLE) && mem_valid && !mem_flush &&
                     !(ale || ld_valid || st_done);
  assign cancelled = cancel_q || mem_flush;

  // Request decode: alignment check, strobe and lane-positioned write data.
  always_comb begin
    ofs        = mem_addr[OFS_W-1:0];
    ofs3       = 3'(ofs);
    misaligned = 1'b0;
    strb_base  = STRB_W'(8'h01);
    wmask      = DATA_W'(64'hFF);
    case (mem_size)
      2'd0: ;
      2'd1: begin
        misaligned = ofs3[0];
        strb_base  = STRB_W'(8'h03);
        wmask      = DATA_W'(64'hFFFF);
      end
      2'd2: begin
        misaligned = (ofs3[1:0] != 2'd0);
        strb_base  = STRB_W'(8'h0F);
        wmask      = DATA_W'(64'hFFFF_FFFF);
      end
      default: begin
        misaligned = (DATA_W == 32) || (ofs3 != 3'd0);
        strb_base  = '1;
        wmask      = '1;
      end
    endcase
    wdata_sh = (mem_wdata & wmask) << {ofs, 3'b000};
    strb_sh  = strb_base << ofs;
  end

  // Response decode: shift the addressed bytes down and extend them.
  always_comb begin
    rd_sh = da_rdata >> {ofs_q, 3'b000};
    keep  = '1;
    sgn   = 1'b0;
    case (size_q)
      2'd0: begin keep = DATA_W'(64'hFF);        sgn = rd_sh[7];  end
      2'd1: begin keep = DATA_W'(64'hFFFF);      sgn = rd_sh[15]; end
      2'd2: begin keep = DATA_W'(64'hFFFF_FFFF); sgn = rd_sh[31]; end
      default: ;
    endcase
    ld_ext = (rd_sh & keep) | ((sgn && !uns_q) ? ~keep : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_next = REQ;
      REQ:     if (da_addr_ok)            state_next = RESP;
      RESP:    if (da_data_ok)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields, latched access attributes, cancel flag and completion pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ale      <= 1'b0;
      ld_valid <= 1'b0;
      st_done  <= 1'b0;
      ld_data  <= '0;
      da_req   <= 1'b0;
      da_wr    <= 1'b0;
      da_wstrb <= '0;
      da_addr  <= '0;
      da_wdata <= '0;
      cancel_q <= 1'b0;
      ofs_q    <= '0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
    end else begin
      ale      <= 1'b0;
      ld_valid <= 1'b0;
      st_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              ale <= 1'b1;
            end else begin
              da_req   <= 1'b1;
              da_wr    <= mem_is_store;
              da_addr  <= {mem_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
              da_wstrb <= mem_is_store ? strb_sh : '0;
              da_wdata <= wdata_sh;
              ofs_q    <= ofs;
              size_q   <= mem_size;
              uns_q    <= mem_unsigned;
            end
          end
        end
        REQ: begin
          if (mem_flush) cancel_q <= 1'b1;
          if (da_addr_ok) begin
            da_req   <= 1'b0;
            da_wr    <= 1'b0;
            da_wstrb <= '0;
          end
        end
        RESP: begin
          if (mem_flush) cancel_q <= 1'b1;
          if (da_data_ok) begin
            cancel_q <= 1'b0;
            if (!cancelled) begin
              if (da_wr_q_store()) st_done <= 1'b1;
              else begin
                ld_valid <= 1'b1;
                ld_data  <= ld_ext;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // da_wr is cleared at the address handshake, so the store/load kind of the
  // outstanding access is kept separately.
  logic is_store_q;

  // Latch whether the outstanding access is a store.
  always_ff @(posedge clk) begin
    if (!rstn)                                 is_store_q <= 1'b0;
    else if (accept && !misaligned)            is_store_q <= mem_is_store;
  end

  function automatic logic da_wr_q_store();
    return is_store_q;
  endfunction

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: drives a 32-bit and a 64-bit controller one at a time
// (sel picks the active one) with directed and random accesses, and checks
// every cycle against a byte-level transaction model.
module tb_mem_req_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        sel;
  logic        mem_valid, mem_flush, mem_is_store, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        da_addr_ok, da_data_ok;
  logic [63:0] da_rdata;
  logic        v32, v64;
  assign v32 = mem_valid & ~sel;
  assign v64 = mem_valid & sel;

  logic        b32, lv32, sd32, al32, rq32, wr32;
  logic [31:0] ld32, ad32, wd32;
  logic [3:0]  sb32;
  logic        b64, lv64, sd64, al64, rq64, wr64;
  logic [63:0] ld64, wd64;
  logic [31:0] ad64;
  logic [7:0]  sb64;

  mem_req_ctrl #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rstn(rstn), .mem_valid(v32), .mem_flush(mem_flush),
    .mem_is_store(mem_is_store), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata[31:0]), .mem_busy(b32),
    .ld_valid(lv32), .ld_data(ld32), .st_done(sd32), .ale(al32),
    .da_req(rq32), .da_wr(wr32), .da_wstrb(sb32), .da_addr(ad32), .da_wdata(wd32),
    .da_addr_ok(da_addr_ok), .da_data_ok(da_data_ok), .da_rdata(da_rdata[31:0])
  );

  mem_req_ctrl #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rstn(rstn), .mem_valid(v64), .mem_flush(mem_flush),
    .mem_is_store(mem_is_store), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(b64),
    .ld_valid(lv64), .ld_data(ld64), .st_done(sd64), .ale(al64),
    .da_req(rq64), .da_wr(wr64), .da_wstrb(sb64), .da_addr(ad64), .da_wdata(wd64),
    .da_addr_ok(da_addr_ok), .da_data_ok(da_data_ok), .da_rdata(da_rdata)
  );

  // View of the active controller, widened to 64 bits.
  logic        o_busy, o_ldv, o_std, o_ale, o_req, o_wr, quiet_other;
  logic [63:0] o_ld, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_strb;
  always_comb begin
    o_busy  = sel ? b64  : b32;
    o_ldv   = sel ? lv64 : lv32;
    o_std   = sel ? sd64 : sd32;
    o_ale   = sel ? al64 : al32;
    o_req   = sel ? rq64 : rq32;
    o_wr    = sel ? wr64 : wr32;
    o_ld    = sel ? ld64 : {32'd0, ld32};
    o_wdata = sel ? wd64 : {32'd0, wd32};
    o_addr  = sel ? ad64 : ad32;
    o_strb  = sel ? sb64 : {4'd0, sb32};
    quiet_other = sel ? (b32 | lv32 | sd32 | al32 | rq32)
                      : (b64 | lv64 | sd64 | al64 | rq64);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errs   = 0;
  logic        checking = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_req  = 1'b0;
  logic        expect_pulse = 1'b0;
  logic [31:0] cur_addr  = '0;
  logic        cur_wr    = 1'b0;
  logic [7:0]  cur_strb  = '0;
  logic [63:0] cur_wdata = '0;
  // {ale, st_done, ld_valid} one-hot kind, then expected ld_data.
  logic [66:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-by-byte view of one access on a bus of dw bits.
  task automatic model(input int dw, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       output logic mis, output logic [31:0] ea, output logic [7:0] es,
                       output logic [63:0] ew, output logic [63:0] el);
    int nb, bpw, ofs;
    nb  = 1 << sz;
    bpw = dw / 8;
    ofs = int'(a[2:0]) % bpw;
    mis = ((ofs % nb) != 0) || (sz == 2'd3 && dw == 32);
    ea  = a - 32'(ofs);
    es  = '0;
    ew  = '0;
    el  = '0;
    for (int i = 0; i < bpw; i++) begin
      if (i >= ofs && i < ofs + nb) begin
        es[i] = st;
        ew[8*i +: 8] = wd[8*(i-ofs) +: 8];
      end
    end
    for (int k = 0; k < nb; k++)
      if (ofs + k < bpw) el[8*k +: 8] = rd[8*(ofs+k) +: 8];
    if (!uns && ofs + nb <= bpw && rd[8*(ofs+nb)-1])
      for (int k = nb; k < bpw; k++) el[8*k +: 8] = 8'hFF;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      int np;
      logic [66:0] e;
      chk("busy", 64'(o_busy), 64'(exp_busy));
      chk("req", 64'(o_req), 64'(exp_req));
      if (o_req) begin
        chk("da_addr", 64'(o_addr), 64'(cur_addr));
        chk("da_wr", 64'(o_wr), 64'(cur_wr));
        chk("da_wstrb", 64'(o_strb), 64'(cur_strb));
        chk("da_wdata", o_wdata, cur_wdata);
      end else begin
        chk("wstrb_idle", 64'(o_strb), 64'd0);
      end
      np = int'(o_ale) + int'(o_std) + int'(o_ldv);
      chk("pulse_excl", 64'(np <= 1), 64'd1);
      chk("pulse_time", 64'(np != 0), 64'(expect_pulse));
      if (np != 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL pulse_unexpected: got {ale,st,ld}=%b, required none", {o_ale, o_std, o_ldv});
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 64'({o_ale, o_std, o_ldv}), 64'(e[66:64]));
          if (o_ldv && e[64]) chk("ld_data", o_ld, e[63:0]);
        end
      end
      chk("other_quiet", 64'(quiet_other), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    da_rdata = {$urandom, $urandom};
  endtask

  task automatic chk_reset();
    chk("rst_req_busy", 64'({rq32, b32, rq64, b64}), 64'd0);
    chk("rst_pulses", 64'({lv32, sd32, al32, lv64, sd64, al64}), 64'd0);
    chk("rst_wr_strb", 64'({wr32, sb32, wr64, sb64}), 64'd0);
    chk("rst_addr", {ad64, ad32}, 64'd0);
    chk("rst_wdata", wd64 | 64'(wd32), 64'd0);
    chk("rst_ld_data", ld64 | 64'(ld32), 64'd0);
  endtask

  // One access from presentation to completion; fl: 0 none, 1 flush in
  // request phase, 2 flush in response phase.
  task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int aw, input int dwt, input int fl,
                        input logic dok_early, input logic rst_mid);
    logic mis, canc;
    logic [31:0] ea;
    logic [7:0]  es;
    logic [63:0] ew, el;
    if (fl == 2 && dwt < 1) dwt = 1;
    model(sel ? 64 : 32, st, sz, uns, a, wd, rd, mis, ea, es, ew, el);
    cur_addr = ea; cur_wr = st; cur_strb = es; cur_wdata = ew;
    mem_is_store = st; mem_size = sz; mem_unsigned = uns;
    mem_addr = a; mem_wdata = wd; mem_flush = 1'b0; mem_valid = 1'b1;
    if (mis) begin
      exp_q.push_back({3'b100, 64'd0});
      tick();
      mem_valid = 1'b0; expect_pulse = 1'b1;
      tick();
      expect_pulse = 1'b0;
    end else begin
      tick();
      exp_req = 1'b1; exp_busy = 1'b1;
      if (rst_mid) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1; mem_valid = 1'b0; exp_req = 1'b0; exp_busy = 1'b0;
        chk_reset();
      end else begin
        for (int i = 0; i < aw; i++) tick();
        da_addr_ok = 1'b1; da_data_ok = dok_early;
        if (fl == 1) begin mem_flush = 1'b1; mem_valid = 1'b0; end
        tick();
        da_addr_ok = 1'b0; da_data_ok = 1'b0; exp_req = 1'b0; mem_flush = 1'b0;
        if (fl == 2) begin mem_flush = 1'b1; mem_valid = 1'b0; end
        for (int i = 0; i < dwt; i++) begin tick(); mem_flush = 1'b0; end
        da_data_ok = 1'b1; da_rdata = rd;
        canc = (fl != 0);
        if (!canc) exp_q.push_back(st ? {3'b010, 64'd0} : {3'b001, el});
        tick();
        da_data_ok = 1'b0; mem_flush = 1'b0; mem_valid = 1'b0;
        exp_busy = 1'b0; expect_pulse = !canc;
        tick();
        expect_pulse = 1'b0;
      end
    end
  endtask

  task automatic idle_flush();
    mem_valid = 1'b1; mem_flush = 1'b1; mem_is_store = 1'b1;
    mem_size = 2'd2; mem_addr = 32'h5002;
    repeat (3) tick();
    mem_valid = 1'b0; mem_flush = 1'b0;
    tick();
  endtask

  task automatic random_accesses(input int n);
    logic [1:0]  sz;
    logic [31:0] a;
    int fl, r;
    for (int t = 0; t < n; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      r  = int'($urandom_range(0, 7));
      fl = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fl,
             ($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  // Hand-computed values that pin the model itself.
  task automatic pin_model();
    logic mis;
    logic [31:0] ea;
    logic [7:0]  es;
    logic [63:0] ew, el;
    model(32, 1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB, 64'd0, mis, ea, es, ew, el);
    chk("pin_sb_addr", 64'(ea), 64'h1000);
    chk("pin_sb_strb", 64'(es), 64'h8);
    chk("pin_sb_wdata", ew, 64'hAB00_0000);
    model(32, 1'b0, 2'd1, 1'b0, 32'h2002, 64'd0, 64'h8001_1234, mis, ea, es, ew, el);
    chk("pin_lh", el, 64'hFFFF_8001);
    model(32, 1'b0, 2'd1, 1'b1, 32'h2002, 64'd0, 64'h8001_1234, mis, ea, es, ew, el);
    chk("pin_lhu", el, 64'h0000_8001);
    model(64, 1'b0, 2'd2, 1'b0, 32'h08, 64'd0, 64'h8765_4321_0000_0000, mis, ea, es, ew, el);
    chk("pin_lw08", {63'd0, mis} | el, 64'd0);
    model(64, 1'b0, 2'd2, 1'b0, 32'h0C, 64'd0, 64'h8765_4321_0000_0000, mis, ea, es, ew, el);
    chk("pin_lw0c", el, 64'hFFFF_FFFF_8765_4321);
    model(32, 1'b1, 2'd2, 1'b0, 32'h1002, 64'd0, 64'd0, mis, ea, es, ew, el);
    chk("pin_sw_mis", 64'(mis), 64'd1);
    model(32, 1'b0, 2'd3, 1'b0, 32'h1000, 64'd0, 64'd0, mis, ea, es, ew, el);
    chk("pin_ld32_mis", 64'(mis), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; sel = 1'b0;
    mem_valid = 1'b0; mem_flush = 1'b0; mem_is_store = 1'b0; mem_unsigned = 1'b0;
    mem_size = 2'd0; mem_addr = '0; mem_wdata = '0;
    da_addr_ok = 1'b0; da_data_ok = 1'b0; da_rdata = '0;
    repeat (3) tick();
    rstn = 1'b1;
    chk_reset();
    checking = 1'b1;
    pin_model();

    // 32-bit controller.
    access(1'b1, 2'd0, 1'b0, 32'h1003, 64'hAB, 64'd0, 0, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd1, 1'b0, 32'h2002, 64'h1111, 64'h8001_1234, 0, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd1, 1'b1, 32'h2002, 64'h2222, 64'h8001_1234, 0, 0, 0, 1'b0, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h1002, 64'h1234_5678, 64'd0, 0, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd3, 1'b0, 32'h1000, 64'd0, 64'd0, 0, 0, 0, 1'b0, 1'b0);
    access(1'b1, 2'd2, 1'b0, 32'h3004, 64'hCAFE_F00D, 64'd0, 5, 1, 0, 1'b0, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h3001, 64'd0, 64'h0000_8000, 1, 2, 2, 1'b0, 1'b0);
    access(1'b0, 2'd0, 1'b0, 32'h3001, 64'd0, 64'h0000_8000, 0, 0, 0, 1'b0, 1'b0);
    access(1'b1, 2'd1, 1'b0, 32'h3006, 64'hBEEF, 64'd0, 2, 1, 1, 1'b0, 1'b0);
    idle_flush();
    access(1'b0, 2'd2, 1'b0, 32'h4000, 64'd0, 64'd0, 0, 0, 0, 1'b0, 1'b1);
    access(1'b0, 2'd2, 1'b1, 32'h4000, 64'd0, 64'hF00D_CAFE, 0, 2, 0, 1'b1, 1'b0);
    random_accesses(60);

    // 64-bit controller.
    tick();
    sel = 1'b1;
    tick();
    access(1'b0, 2'd2, 1'b0, 32'h08, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h0C, 64'd0, 64'h8765_4321_0000_0000, 0, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 64'hFEDC_BA98_7654_3210, 1, 1, 0, 1'b0, 1'b0);
    access(1'b1, 2'd3, 1'b0, 32'h18, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 0, 1'b0, 1'b0);
    access(1'b1, 2'd1, 1'b0, 32'h0E, 64'hA5A5, 64'd0, 3, 0, 0, 1'b0, 1'b0);
    access(1'b0, 2'd3, 1'b0, 32'h14, 64'd0, 64'd0, 0, 0, 0, 1'b0, 1'b0);
    random_accesses(60);

    repeat (4) tick();
    checking = 1'b0;
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
